// File: rtl/pll_mon_pkg.sv
// ============================================================================
// Module      : pll_mon_pkg
// Description : Shared types and defaults for the PLL lock monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_mon_pkg;

    // Monitor state encoding, visible on the state output
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } pll_state_e;

    localparam int DEF_WIN_W    = 12;
    localparam int DEF_CNT_W    = 12;
    localparam int DEF_LOCK_N   = 4;
    localparam int DEF_UNLOCK_N = 2;
    localparam int TOL_W        = 8;

    // Shortest usable window; shorter programmed lengths are promoted to this
    localparam int MIN_WIN      = 2;

    // Bits needed to hold a run-length counter that counts 0..n-1
    function automatic int run_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_edge_sync.sv
// ============================================================================
// Module      : pll_edge_sync
// Description : Two-flop synchroniser for an asynchronous input followed by a
//               delay flop; emits a one-cycle pulse on each synchronised
//               0->1 transition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Metastability chain plus one delay stage for edge comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~dly_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_monitor.sv
// ============================================================================
// Module      : pll_lock_monitor
// Description : Counts edges of the divided PLL clock over a programmable
//               window of system clocks, judges each window against a target
//               with tolerance, and tracks lock with hysteresis.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int WIN_W    = DEF_WIN_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_N   = DEF_LOCK_N,
    parameter int UNLOCK_N = DEF_UNLOCK_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pll_div_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] target,
    input  logic [TOL_W-1:0] tol,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             locked,
    output logic [1:0]       state,
    output logic             loss_sticky
);

    // Deviation arithmetic is wide enough for both the count and tolerance
    localparam int DW   = (CNT_W + 1 > TOL_W) ? CNT_W + 1 : TOL_W;
    localparam int GC_W = run_cnt_w(LOCK_N);
    localparam int BC_W = run_cnt_w(UNLOCK_N);

    pll_state_e       state_q;
    pll_state_e       state_d;

    logic [WIN_W-1:0] win_cnt_q;
    logic [WIN_W-1:0] win_len_q;
    logic [CNT_W-1:0] target_q;
    logic [TOL_W-1:0] tol_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W-1:0] count_out_q;
    logic             count_valid_q;
    logic             good_q;
    logic [GC_W-1:0]  good_cnt_q;
    logic [BC_W-1:0]  bad_cnt_q;
    logic             loss_q;
    logic             locked_w;

    logic             edge_pulse;
    logic [WIN_W-1:0] win_len_eff;
    logic             win_last;
    logic             active;
    logic [CNT_W-1:0] edge_next;
    logic [DW-1:0]    cnt_x;
    logic [DW-1:0]    tgt_x;
    logic [DW-1:0]    diff;
    logic             win_good;

    pll_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (pll_div_in),
        .pulse_o (edge_pulse)
    );

    assign active      = (state_q != ST_IDLE);
    assign win_len_eff = (win_len < WIN_W'(MIN_WIN)) ? WIN_W'(MIN_WIN) : win_len;
    assign win_last    = (win_cnt_q == (win_len_q - WIN_W'(1)));

    // Count including an edge seen this cycle, saturating at all-ones
    assign edge_next = (edge_pulse && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1)
                                                          : edge_cnt_q;

    // A saturated count only passes when the target itself is all-ones
    assign cnt_x    = DW'(edge_next);
    assign tgt_x    = DW'(target_q);
    assign diff     = (cnt_x >= tgt_x) ? (cnt_x - tgt_x) : (tgt_x - cnt_x);
    assign win_good = (diff <= DW'(tol_q)) &&
                      !((edge_next == '1) && (target_q != '1));

    // Window timing, edge counting, result capture and config latching
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q     <= '0;
            win_len_q     <= WIN_W'(MIN_WIN);
            target_q      <= '0;
            tol_q         <= '0;
            edge_cnt_q    <= '0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            good_q        <= 1'b0;
        end else if (!en) begin
            win_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            count_valid_q <= 1'b0;
            good_q        <= 1'b0;
        end else if (!active) begin
            win_len_q     <= win_len_eff;
            target_q      <= target;
            tol_q         <= tol;
            win_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            count_valid_q <= 1'b0;
        end else if (win_last) begin
            count_out_q   <= edge_next;
            count_valid_q <= 1'b1;
            good_q        <= win_good;
            win_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            win_len_q     <= win_len_eff;
            target_q      <= target;
            tol_q         <= tol;
        end else begin
            win_cnt_q     <= win_cnt_q + WIN_W'(1);
            edge_cnt_q    <= edge_next;
            count_valid_q <= 1'b0;
        end
    end

    // Hysteresis run counters and the sticky loss flag
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            loss_q     <= 1'b0;
        end else begin
            if (count_valid_q) begin
                case (state_q)
                    ST_ACQUIRE: begin
                        bad_cnt_q <= '0;
                        if (good_q && (good_cnt_q != GC_W'(LOCK_N - 1))) begin
                            good_cnt_q <= good_cnt_q + GC_W'(1);
                        end else begin
                            good_cnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        good_cnt_q <= '0;
                        if (!good_q && (bad_cnt_q != BC_W'(UNLOCK_N - 1))) begin
                            bad_cnt_q <= bad_cnt_q + BC_W'(1);
                        end else begin
                            bad_cnt_q <= '0;
                        end
                    end
                    default: begin
                        good_cnt_q <= '0;
                        bad_cnt_q  <= '0;
                    end
                endcase
            end
            if ((state_q == ST_LOCKED) && (state_d == ST_ACQUIRE)) begin
                loss_q <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision, taken on the count_valid cycle
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (count_valid_q && good_q && (good_cnt_q == GC_W'(LOCK_N - 1))) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (count_valid_q && !good_q && (bad_cnt_q == BC_W'(UNLOCK_N - 1))) begin
                        state_d = ST_ACQUIRE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        locked_w = (state_q == ST_LOCKED);
    end

    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign locked      = locked_w;
    assign state       = state_q;
    assign loss_sticky = loss_q;

endmodule

`default_nettype wire
